cmd_issue_queue: RTL and testbench

CMD_ISSUE_QUEUE -- requirements
Module: cmd_issue_queue

---
 rtl/cmd_issue_queue.sv | 68 ++++++
 tb/tb_cmd_issue_queue.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/cmd_issue_queue.sv
// cmd_issue_queue: validating command FIFO that issues one registered command per permitted cycle
// Ports:
//   clk, reset                  - clock, synchronous active-high reset
//   in_valid/in_ready           - upstream handshake; in_op_code/in_address/in_data form the command
//   out_en                      - downstream permits an issue this cycle
//   op_code/address/data        - registered issued command, zero when nothing issues
//   issue_valid                 - outputs hold a freshly issued command
//   err_op/err_addr             - one-cycle pulses for commands dropped on bad opcode/address
//   level, issued_cnt           - FIFO occupancy, wrapping count of issued commands
module cmd_issue_queue #(
  parameter int DEPTH    = 4,
  parameter int ADDR_MAX = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_op_code,
  input  logic [7:0]               in_address,
  input  logic [15:0]              in_data,
  input  logic                     out_en,
  output logic [7:0]               op_code,
  output logic [7:0]               address,
  output logic [15:0]              data,
  output logic                     issue_valid,
  output logic                     err_addr,
  output logic                     err_op,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              issued_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          acc, bad_op, bad_addr, push, pop;
  // level never exceeds DEPTH = 2**AW, so its top bit alone means full
  assign in_ready = !reset && !level[AW];
  always_comb begin
    acc      = in_valid && in_ready;
    bad_op   = in_op_code == 8'd0 || in_op_code > 8'd4;
    bad_addr = in_address > 8'(ADDR_MAX);
    push     = acc && !bad_op && !bad_addr;
    pop      = out_en && level != '0;
  end
  // in_ready is low during reset, so no write can slip in then
  always_ff @(posedge clk)
    if (push) mem[wp] <= {in_op_code, in_address, in_data};
  always_ff @(posedge clk) begin
    if (reset) begin
      wp                       <= '0;
      rp                       <= '0;
      level                    <= '0;
      issued_cnt               <= '0;
      {op_code, address, data} <= '0;
      issue_valid              <= 1'b0;
      err_op                   <= 1'b0;
      err_addr                 <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      level                    <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      issued_cnt               <= issued_cnt + {15'd0, pop};
      {op_code, address, data} <= pop ? mem[rp] : 32'd0;
      issue_valid              <= pop;
      err_op                   <= acc && bad_op;
      err_addr                 <= acc && bad_addr;
    end
  end
endmodule

// File: tb/tb_cmd_issue_queue.sv
// tb_cmd_issue_queue: directed self-checking bench for cmd_issue_queue
module tb_cmd_issue_queue;
  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_en;
  logic [7:0]  in_op_code, in_address, op_code, address;
  logic [15:0] in_data, data, issued_cnt;
  logic        issue_valid, err_addr, err_op;
  logic [2:0]  level;
  int          errors = 0;
  int          checks = 0;

  cmd_issue_queue #(.DEPTH(4), .ADDR_MAX(7)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op_code(in_op_code), .in_address(in_address), .in_data(in_data),
    .out_en(out_en), .op_code(op_code), .address(address), .data(data),
    .issue_valid(issue_valid), .err_addr(err_addr), .err_op(err_op),
    .level(level), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [7:0] op, input logic [7:0] ad, input logic [15:0] d, input logic oe);
    @(negedge clk);
    in_valid   = v;
    in_op_code = op;
    in_address = ad;
    in_data    = d;
    out_en     = oe;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 16'h0000, 1'b0);
    step();
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b exp 0", in_ready); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d exp 0", level); end
    checks++; if ({issue_valid, err_op, err_addr} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", {issue_valid, err_op, err_addr}); end
    checks++; if ({op_code, address, data, issued_cnt} !== 48'd0) begin errors++; $display("FAIL reset_outputs: got %h exp 0", {op_code, address, data, issued_cnt}); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_single;
    drive(1'b1, 8'h01, 8'h03, 16'h1234, 1'b1);
    step();
    checks++; if ({level, issue_valid} !== {3'd1, 1'b0}) begin errors++; $display("FAIL single_no_bypass: got level=%0d iv=%b exp 1 0", level, issue_valid); end
    drive(1'b0, 8'h00, 8'h00, 16'h0000, 1'b1);
    step();
    checks++; if ({op_code, address, data} !== 32'h0103_1234) begin errors++; $display("FAIL single_issue: got %h exp 01031234", {op_code, address, data}); end
    checks++; if ({issue_valid, issued_cnt, level} !== {1'b1, 16'd1, 3'd0}) begin errors++; $display("FAIL single_status: got iv=%b cnt=%0d lvl=%0d exp 1 1 0", issue_valid, issued_cnt, level); end
    step();
    checks++; if ({issue_valid, op_code, data} !== 25'd0) begin errors++; $display("FAIL single_idle: got iv=%b op=%h d=%h exp 0", issue_valid, op_code, data); end
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'((i % 4) + 1), 8'(i), 16'hA000 + 16'(i), 1'b0);
      #1;
      checks++; if (in_ready !== (i < 4)) begin errors++; $display("FAIL fill_in_ready_%0d: got %b exp %b", i, in_ready, i < 4); end
      step();
    end
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level: got %0d exp 4", level); end
    drive(1'b0, 8'h00, 8'h00, 16'h0000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({issue_valid, op_code, address, data} !== {1'b1, 8'((i % 4) + 1), 8'(i), 16'hA000 + 16'(i)}) begin
        errors++; $display("FAIL drain_%0d: got iv=%b %h/%h/%h exp %0d/%0d/%h", i, issue_valid, op_code, address, data, (i % 4) + 1, i, 16'hA000 + 16'(i));
      end
    end
    checks++; if ({level, issued_cnt} !== {3'd0, 16'd5}) begin errors++; $display("FAIL drain_end: got lvl=%0d cnt=%0d exp 0 5", level, issued_cnt); end
    step();
    checks++; if ({issue_valid, level} !== 4'b0000) begin errors++; $display("FAIL empty_pop: got iv=%b lvl=%0d exp 0 0", issue_valid, level); end
  endtask

  task automatic test_errors;
    drive(1'b1, 8'h05, 8'h02, 16'hEEEE, 1'b0);
    step();
    checks++; if ({err_op, err_addr, level, issue_valid} !== {1'b1, 1'b0, 3'd0, 1'b0}) begin errors++; $display("FAIL err_op: got eo=%b ea=%b lvl=%0d iv=%b exp 1 0 0 0", err_op, err_addr, level, issue_valid); end
    drive(1'b0, 8'h00, 8'h00, 16'h0000, 1'b1);
    step();
    checks++; if ({err_op, err_addr, issue_valid} !== 3'b000) begin errors++; $display("FAIL err_op_pulse: got eo=%b ea=%b iv=%b exp 000", err_op, err_addr, issue_valid); end
    drive(1'b1, 8'h02, 8'h08, 16'hEEEE, 1'b0);
    step();
    checks++; if ({err_op, err_addr, level} !== {1'b0, 1'b1, 3'd0}) begin errors++; $display("FAIL err_addr: got eo=%b ea=%b lvl=%0d exp 0 1 0", err_op, err_addr, level); end
    drive(1'b1, 8'h00, 8'hFF, 16'hEEEE, 1'b0);
    step();
    checks++; if ({err_op, err_addr, level} !== {1'b1, 1'b1, 3'd0}) begin errors++; $display("FAIL err_both: got eo=%b ea=%b lvl=%0d exp 1 1 0", err_op, err_addr, level); end
    drive(1'b0, 8'h00, 8'h00, 16'h0000, 1'b0);
    step();
    checks++; if ({err_op, err_addr, issue_valid, issued_cnt} !== {3'b000, 16'd5}) begin errors++; $display("FAIL err_clear: got eo=%b ea=%b iv=%b cnt=%0d exp 0 0 0 5", err_op, err_addr, issue_valid, issued_cnt); end
  endtask

  task automatic test_back_to_back;
    drive(1'b1, 8'h01, 8'h01, 16'hB001, 1'b0);
    drive(1'b1, 8'h02, 8'h02, 16'hB002, 1'b0);
    step();
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL b2b_level: got %0d exp 2", level); end
    drive(1'b1, 8'h03, 8'h03, 16'hB003, 1'b1);
    step();
    checks++; if ({level, issue_valid, op_code, data} !== {3'd2, 1'b1, 8'h01, 16'hB001}) begin errors++; $display("FAIL b2b_push_pop: got lvl=%0d iv=%b op=%h d=%h exp 2 1 01 b001", level, issue_valid, op_code, data); end
    drive(1'b0, 8'h00, 8'h00, 16'h0000, 1'b1);
    step();
    checks++; if ({op_code, address, data} !== 32'h0202_B002) begin errors++; $display("FAIL b2b_second: got %h exp 0202b002", {op_code, address, data}); end
    step();
    checks++; if ({op_code, address, data, level, issued_cnt} !== {32'h0303_B003, 3'd0, 16'd8}) begin errors++; $display("FAIL b2b_third: got %h lvl=%0d cnt=%0d exp 0303b003 0 8", {op_code, address, data}, level, issued_cnt); end
  endtask

  task automatic test_full_pop;
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h04, 8'h07, 16'hC001 + 16'(i), 1'b0);
    step();
    checks++; if ({level, in_ready} !== {3'd4, 1'b0}) begin errors++; $display("FAIL full: got lvl=%0d rdy=%b exp 4 0", level, in_ready); end
    drive(1'b1, 8'h01, 8'h00, 16'hDEAD, 1'b1);
    step();
    checks++; if ({level, in_ready, data} !== {3'd3, 1'b1, 16'hC001}) begin errors++; $display("FAIL full_pop: got lvl=%0d rdy=%b d=%h exp 3 1 c001", level, in_ready, data); end
    drive(1'b0, 8'h00, 8'h00, 16'h0000, 1'b1);
    step();
    step();
    step();
    checks++; if ({level, data, issued_cnt} !== {3'd0, 16'hC004, 16'd12}) begin errors++; $display("FAIL full_drain: got lvl=%0d d=%h cnt=%0d exp 0 c004 12", level, data, issued_cnt); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h01, 8'h01, 16'hD001 + 16'(i), 1'b0);
    step();
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_level: got %0d exp 3", level); end
    drive(1'b0, 8'h00, 8'h00, 16'h0000, 1'b1);
    reset = 1'b1;
    step();
    checks++; if ({level, issue_valid, in_ready, issued_cnt} !== {3'd0, 1'b0, 1'b0, 16'd0}) begin errors++; $display("FAIL mid_reset: got lvl=%0d iv=%b rdy=%b cnt=%0d exp 0 0 0 0", level, issue_valid, in_ready, issued_cnt); end
    checks++; if ({op_code, address, data} !== 32'd0) begin errors++; $display("FAIL mid_reset_out: got %h exp 0", {op_code, address, data}); end
    @(negedge clk);
    reset = 1'b0;
    step();
    step();
    checks++; if ({level, issue_valid, data, issued_cnt} !== 36'd0) begin errors++; $display("FAIL mid_stale: got lvl=%0d iv=%b d=%h cnt=%0d exp 0", level, issue_valid, data, issued_cnt); end
  endtask

  task automatic test_cnt_wrap;
    drive(1'b1, 8'h02, 8'h05, 16'h5A5A, 1'b1);
    repeat (65536) @(posedge clk);
    #1;
    checks++; if ({issued_cnt, level} !== {16'hFFFF, 3'd1}) begin errors++; $display("FAIL cnt_max: got cnt=%h lvl=%0d exp ffff 1", issued_cnt, level); end
    drive(1'b0, 8'h00, 8'h00, 16'h0000, 1'b1);
    step();
    checks++; if ({issued_cnt, level, issue_valid, data} !== {16'h0000, 3'd0, 1'b1, 16'h5A5A}) begin errors++; $display("FAIL cnt_wrap: got cnt=%h lvl=%0d iv=%b d=%h exp 0000 0 1 5a5a", issued_cnt, level, issue_valid, data); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_errors();
    test_back_to_back();
    test_full_pop();
    test_reset_mid();
    test_cnt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
